// File: rtl/mem_io_pkg.sv
// Shared decode constants and status-byte packing for the CPU memory/I-O bridge.
package mem_io_pkg;

    localparam logic [1:0]  IO_SEL    = 2'b11;
    localparam int unsigned OFF_BIT   = 2;
    localparam int unsigned ST_RXNE   = 0;
    localparam int unsigned ST_TXFULL = 1;
    localparam int unsigned ST_DONE   = 2;

    function automatic logic [7:0] status_byte(input logic done,
                                               input logic tx_full,
                                               input logic rx_nempty);
        logic [7:0] s;
        s            = '0;
        s[ST_RXNE]   = rx_nempty;
        s[ST_TXFULL] = tx_full;
        s[ST_DONE]   = done;
        return s;
    endfunction

endpackage

// File: rtl/mem_io_bridge_byte_fifo.sv
// Circular byte FIFO with one extra pointer bit to tell full from empty.
module byte_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] r_wp;
    logic [AW:0] r_rp;
    logic [7:0]  r_mem [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign empty = (r_wp == r_rp);
    assign full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign dout  = r_mem[r_rp[AW-1:0]];

    // A push onto a full FIFO is accepted only when the head leaves in the same cycle.
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_do_push) r_wp <= r_wp + 1'b1;
            if (w_do_pop)  r_rp <= r_rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wp[AW-1:0]] <= din;
    end

endmodule

// File: rtl/mem_io_bridge.sv
// Routes CPU byte accesses to synchronous RAM or to the TX/RX/status I/O window,
// returning all read data with the same 1-cycle latency.
module mem_io_bridge
    import mem_io_pkg::*;
#(
    parameter int unsigned ADDR_W     = 17,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       cpu_a,
    input  logic              cpu_wr,
    input  logic [7:0]        cpu_wn,
    output logic [7:0]        cpu_rn,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr,
    output logic [7:0]        ram_wn,
    input  logic [7:0]        ram_rn,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              done,
    output logic              tx_ovf
);

    logic       w_io;
    logic       w_rd_data;
    logic       w_wr_data;
    logic       w_wr_stat;
    logic       w_tx_pop;
    logic       w_tx_full;
    logic       w_tx_empty;
    logic       w_rx_pop;
    logic       w_rx_push;
    logic       w_rx_full;
    logic       w_rx_empty;
    logic [7:0] w_rx_head;
    logic [7:0] w_io_rd;
    logic       w_unused;

    logic       r_io_q;
    logic [7:0] r_io_rd_q;
    logic       r_rd_data_q;
    logic       r_done;
    logic       r_tx_ovf;

    assign w_unused  = &{1'b0, cpu_a};

    assign w_io      = (cpu_a[17:16] == IO_SEL);
    assign w_rd_data = w_io & ~cpu_a[OFF_BIT] & ~cpu_wr;
    assign w_wr_data = w_io & ~cpu_a[OFF_BIT] &  cpu_wr;
    assign w_wr_stat = w_io &  cpu_a[OFF_BIT] &  cpu_wr;

    assign ram_a  = cpu_a[ADDR_W-1:0];
    assign ram_wn = cpu_wn;
    assign ram_wr = cpu_wr & ~w_io;

    assign w_tx_pop  = ~w_tx_empty & tx_ready;
    assign w_rx_push = rx_valid & ~w_rx_full;
    assign w_rx_pop  = w_rd_data & ~r_rd_data_q & ~w_rx_empty;

    assign tx_valid = ~w_tx_empty;
    assign rx_ready = ~w_rx_full;
    assign done     = r_done;
    assign tx_ovf   = r_tx_ovf;

    always_comb begin
        w_io_rd = '0;
        if (cpu_a[OFF_BIT]) w_io_rd = status_byte(r_done, w_tx_full, ~w_rx_empty);
        else if (!w_rx_empty) w_io_rd = w_rx_head;
    end

    assign cpu_rn = r_io_q ? r_io_rd_q : ram_rn;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_io_q      <= 1'b1;
            r_io_rd_q   <= '0;
            r_rd_data_q <= 1'b0;
            r_done      <= 1'b0;
            r_tx_ovf    <= 1'b0;
        end else begin
            r_io_q      <= w_io;
            r_rd_data_q <= w_rd_data;
            // A held DATA read keeps the byte it popped, not the new head behind it.
            if (!(w_rd_data && r_rd_data_q)) r_io_rd_q <= w_io_rd;
            if (w_wr_stat) r_done <= 1'b1;
            if (w_wr_data && w_tx_full && !w_tx_pop) r_tx_ovf <= 1'b1;
        end
    end

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_wr_data),
        .pop   (w_tx_pop),
        .din   (cpu_wn),
        .dout  (tx_data),
        .full  (w_tx_full),
        .empty (w_tx_empty)
    );

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_rx_push),
        .pop   (w_rx_pop),
        .din   (rx_data),
        .dout  (w_rx_head),
        .full  (w_rx_full),
        .empty (w_rx_empty)
    );

endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed bench for mem_io_bridge with a small synchronous RAM model.
module tb_mem_io_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpu_a;
    logic        cpu_wr;
    logic [7:0]  cpu_wn;
    logic [7:0]  cpu_rn;
    logic [16:0] ram_a;
    logic        ram_wr;
    logic [7:0]  ram_wn;
    logic [7:0]  ram_rn;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        done;
    logic        tx_ovf;

    int checks = 0;
    int errors = 0;

    logic [7:0] ram_mem [256];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wr) ram_mem[ram_a[7:0]] <= ram_wn;
        ram_rn <= ram_mem[ram_a[7:0]];
    end

    mem_io_bridge #(.ADDR_W(17), .FIFO_DEPTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .cpu_a    (cpu_a),
        .cpu_wr   (cpu_wr),
        .cpu_wn   (cpu_wn),
        .cpu_rn   (cpu_rn),
        .ram_a    (ram_a),
        .ram_wr   (ram_wr),
        .ram_wn   (ram_wn),
        .ram_rn   (ram_rn),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .done     (done),
        .tx_ovf   (tx_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic wr, input logic [7:0] wn);
        cpu_a  = a;
        cpu_wr = wr;
        cpu_wn = wn;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram_mem[i] = 8'h00;
        rst = 1'b1; cpu_a = '0; cpu_wr = 1'b0; cpu_wn = '0;
        tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
        cyc(); cyc();
        chk("rst_cpu_rn", cpu_rn, 8'h00);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_rx_ready", rx_ready, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_tx_ovf", tx_ovf, 1'b0);
        rst = 1'b0;

        // RAM round trip
        drive(32'h00010, 1'b1, 8'hA5);
        chk("ram_wr_on_write", ram_wr, 1'b1);
        chk("ram_a", ram_a, 17'h00010);
        chk("ram_wn", ram_wn, 8'hA5);
        cyc();
        drive(32'h00010, 1'b0, 8'h00);
        chk("ram_wr_on_read", ram_wr, 1'b0);
        cyc();
        chk("ram_read_back", cpu_rn, 8'hA5);

        // TX stream
        drive(32'h30000, 1'b1, 8'h48);
        chk("io_write_no_ram", ram_wr, 1'b0);
        cyc();
        drive(32'h30000, 1'b1, 8'h69);
        cyc();
        drive(32'h00000, 1'b0, 8'h00);
        chk("tx_valid_H", tx_valid, 1'b1);
        chk("tx_data_H", tx_data, 8'h48);
        tx_ready = 1'b1;
        cyc();
        chk("tx_valid_i", tx_valid, 1'b1);
        chk("tx_data_i", tx_data, 8'h69);
        cyc();
        chk("tx_empty_after_drain", tx_valid, 1'b0);
        tx_ready = 1'b0;
        chk("tx_ovf_clear", tx_ovf, 1'b0);

        // TX overflow: 17 writes into a 16-deep FIFO
        for (int i = 1; i <= 17; i++) begin
            drive(32'h30000, 1'b1, 8'(i));
            cyc();
        end
        drive(32'h30004, 1'b0, 8'h00);
        cyc();
        chk("stat_tx_full", cpu_rn, 8'h02);
        chk("tx_ovf_set", tx_ovf, 1'b1);
        drive(32'h00000, 1'b0, 8'h00);
        tx_ready = 1'b1;
        #1;
        for (int i = 1; i <= 16; i++) begin
            chk("tx_drain_order", tx_data, 32'(i));
            cyc();
        end
        chk("tx_drained", tx_valid, 1'b0);
        tx_ready = 1'b0;

        // RX push and held read
        rx_valid = 1'b1; rx_data = 8'h31;
        cyc();
        rx_data = 8'h32;
        cyc();
        rx_valid = 1'b0;
        drive(32'h30000, 1'b0, 8'h00);
        cyc();
        chk("rx_hold_1", cpu_rn, 8'h31);
        cyc();
        chk("rx_hold_2", cpu_rn, 8'h31);
        cyc();
        chk("rx_hold_3", cpu_rn, 8'h31);
        drive(32'h30004, 1'b0, 8'h00);
        cyc();
        chk("stat_rx_one_left", cpu_rn, 8'h01);
        drive(32'h30000, 1'b0, 8'h00);
        cyc();
        chk("rx_second", cpu_rn, 8'h32);
        drive(32'h30004, 1'b0, 8'h00);
        cyc();
        chk("stat_rx_empty", cpu_rn, 8'h00);

        // Empty read and done
        drive(32'h30000, 1'b0, 8'h00);
        cyc();
        chk("rx_empty_read", cpu_rn, 8'h00);
        drive(32'h30004, 1'b1, 8'h5A);
        chk("stat_write_no_ram", ram_wr, 1'b0);
        cyc();
        chk("done_set", done, 1'b1);
        drive(32'h30004, 1'b0, 8'h00);
        cyc();
        chk("stat_done", cpu_rn, 8'h04);

        // Reset mid-stream: 3 bytes in TX, 2 in RX
        rx_valid = 1'b1; rx_data = 8'hC1;
        drive(32'h30000, 1'b1, 8'hB1);
        cyc();
        rx_data = 8'hC2;
        drive(32'h30000, 1'b1, 8'hB2);
        cyc();
        rx_valid = 1'b0;
        drive(32'h30000, 1'b1, 8'hB3);
        cyc();
        drive(32'h30004, 1'b0, 8'h00);
        cyc();
        chk("stat_before_rst", cpu_rn, 8'h05);
        chk("tx_valid_before_rst", tx_valid, 1'b1);
        drive(32'h30000, 1'b0, 8'h00);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_tx_valid", tx_valid, 1'b0);
        chk("arst_rx_ready", rx_ready, 1'b1);
        chk("arst_done", done, 1'b0);
        chk("arst_tx_ovf", tx_ovf, 1'b0);
        chk("arst_cpu_rn", cpu_rn, 8'h00);
        #1;
        rst = 1'b0;
        cyc();
        chk("post_rst_read", cpu_rn, 8'h00);
        chk("post_rst_tx_empty", tx_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_io_bridge.md
Name: mem_io_bridge

Overview:
- Sits directly downstream of the CPU top. It consumes the CPU's byte-wide memory bus (address, write enable, write byte) and returns read bytes.
- Decodes each access to either external synchronous RAM or a small memory-mapped I/O region.
- The I/O region holds a TX byte FIFO, an RX byte FIFO, a status register and a sticky program-done flag.
- Read data always returns with 1-cycle latency, matching the synchronous RAM, so the CPU's memory controller sees one uniform timing.

Parameters:
- ADDR_W, 17, RAM address width; ram_a = cpu_a[ADDR_W-1:0].
- FIFO_DEPTH, 16, entries per TX/RX FIFO; must be a power of 2, at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_a  in  32  byte address from CPU.
- cpu_wr  in  1  1 = write, 0 = read; a request is present every cycle.
- cpu_wn  in  8  write byte.
- cpu_rn  out  8  read byte; valid 1 cycle after the address.
- ram_a  out  ADDR_W  RAM address.
- ram_wr  out  1  RAM write enable.
- ram_wn  out  8  RAM write byte.
- ram_rn  in  8  RAM read byte; 1-cycle latency.
- tx_data  out  8  TX FIFO head.
- tx_valid  out  1  TX FIFO non-empty.
- tx_ready  in  1  consumer accepts tx_data.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  incoming byte valid.
- rx_ready  out  1  RX FIFO not full.
- done  out  1  sticky program-done flag.
- tx_ovf  out  1  sticky TX overflow flag.

Behaviour:
- Decode: io = (cpu_a[17:16] == 2'b11).
  - DATA = io & cpu_a[2] == 0 (0x30000).
  - STAT = io & cpu_a[2] == 1 (0x30004).
  - Other low bits are ignored inside the I/O region.
- RAM path is combinational:
  - ram_a = cpu_a[ADDR_W-1:0].
  - ram_wn = cpu_wn.
  - ram_wr = cpu_wr & ~io. I/O writes never reach RAM.
- Read return:
  - The registers io_q and io_rd_q capture state every cycle.
  - cpu_rn = io_q ? io_rd_q : ram_rn.
- I/O read values, computed in the request cycle and presented in the next cycle:
  - DATA read: RX head, or 8'h00 if RX is empty.
  - STAT read: {5'b0, done, tx_full, ~rx_empty}.
- RX pop:
  - Occurs on a DATA read only when the previous cycle was not a DATA read (edge detect via a rd_data_q register).
  - A held address therefore pops once.
  - A read while RX is empty does not pop.
- TX push:
  - A DATA write pushes cpu_wn when not full, or when full with a TX pop in the same cycle.
  - Otherwise the byte is dropped and tx_ovf is set.
  - Every write cycle pushes; writes are not edge-detected.
- TX pop: tx_valid & tx_ready, in the same cycle. tx_valid = ~tx_empty; tx_data = head.
- RX push:
  - Occurs on rx_valid & rx_ready, with rx_ready = ~rx_full.
  - A simultaneous push and pop on a full RX FIFO is not possible, because rx_ready = 0 when full.
- done: set by any STAT write; held until rst.
- FIFOs:
  - Circular buffers with log2(FIFO_DEPTH)+1-bit read/write pointers; full/empty come from MSB compare.
  - Pointers wrap modulo 2*FIFO_DEPTH.
  - A simultaneous push and pop leaves the count unchanged.
- Reset (asynchronous) values:
  - FIFOs empty.
  - io_q = 1 and io_rd_q = 0, so cpu_rn = 8'h00.
  - rd_data_q = 0.
  - done = 0, tx_ovf = 0, tx_valid = 0, rx_ready = 1.
  - FIFO storage contents are not reset.
- Reset mid-operation:
  - All queued bytes are discarded.
  - A pending read returns 8'h00 in the first cycle after release.

Decomposition:
- Package mem_io_pkg holds:
  - IO_SEL = 2'b11.
  - Offset bit index 2.
  - Status bit indices ST_RXNE = 0, ST_TXFULL = 1, ST_DONE = 2.
- Sub-module byte_fifo:
  - Parameter DEPTH.
  - Ports push, pop, din, dout, full, empty.
  - Instantiated twice: TX and RX.

Test Plan:
- RAM round trip: write 8'hA5 to 0x00010, then read 0x00010. ram_wr = 1 on the write cycle; cpu_rn = 8'hA5 one cycle after the read address.
- TX stream: write 'H' (8'h48) then 'i' (8'h69) to 0x30000 with tx_ready = 0. Expect ram_wr = 0 and tx_valid = 1 with tx_data = 8'h48. Raise tx_ready: tx_data = 8'h69 on the next cycle, then tx_valid = 0.
- TX overflow: with tx_ready = 0, write 17 bytes to 0x30000. Status read returns 8'h02 and tx_ovf = 1; bytes 1–16 drain in order.
- RX read: push 8'h31 and 8'h32 via rx_valid. Hold a read of 0x30000 for 3 cycles: cpu_rn = 8'h31 for the whole hold, and only one pop. Then read 0x30004 and get 8'h01. A fresh 0x30000 read returns 8'h32, and RX is then empty.
- Empty read / done: read 0x30000 with RX empty and get 8'h00. Write 0x30004: done = 1, and a status read returns 8'h04.
- Reset mid-stream: with 3 bytes in TX and 2 in RX, assert rst asynchronously between edges. Immediately tx_valid = 0, rx_ready = 1, done = 0 and cpu_rn = 8'h00.
